oam_dma_engine: RTL and testbench
=================================

Name: oam_dma_engine

Overview:
- Bus-initiator counterpart to the memory controller's responder path. It implements the $FF46 OAM DMA register and, once triggered, masters the memory bus to copy 160 bytes from {src_hi, 8'h00} into OAM at $FE00-$FE9F.
- Top level muxes A_dma/Do_dma/rd_dma_n/wr_dma_n onto the memory controller's CPU-side inputs while dma_active=1, and stalls the CPU for that period.

Parameters:
- REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- DEST_BASE, 16'hFE00, first OAM destination address.
- LENGTH, 160, bytes per transfer (1..256).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- A_cpu  in  16  CPU address bus
- Di_cpu  in  8  CPU write data
- wr_cpu_n  in  1  CPU write strobe, active-low
- Do_reg  out  8  readback value of REG_ADDR (last written byte)
- cs_reg  out  1  high when A_cpu==REG_ADDR (combinational)
- A_dma  out  16  DMA bus address
- Do_dma  out  8  DMA write data
- Di_dma  in  8  read data returned by the memory controller
- rd_dma_n  out  1  DMA read strobe, active-low
- wr_dma_n  out  1  DMA write strobe, active-low
- dma_active  out  1  DMA owns the bus; CPU must be stalled

Behaviour:
- Reset
  - state=IDLE, Do_reg=8'h00, src_hi=0, index=0, data latch=0, wr_prev=1.
  - A_dma=16'h0000, Do_dma=8'h00, rd_dma_n=1, wr_dma_n=1, dma_active=0.
  - Reset mid-transfer aborts immediately; no further strobes.
- Trigger
  - wr_prev registers wr_cpu_n each cycle.
  - A trigger is a posedge where A_cpu==REG_ADDR, wr_cpu_n=0 and wr_prev=1. This is falling-edge detection, so a multi-cycle write triggers once.
  - On trigger: Do_reg<=Di_cpu; src_hi<=Di_cpu, minus 8'h20 if Di_cpu>=8'hE0 (echo remap: E0->C0, FE->DE, FF->DF); index<=0; state<=SETUP.
- States
  - IDLE: strobes high, dma_active=0.
  - SETUP: one cycle, dma_active=1, strobes high. Next state is READ.
  - READ: A_dma={src_hi,index}, rd_dma_n=0. At the posedge ending READ, latch Di_dma into the data latch. Next state is WRITE.
  - WRITE: A_dma=DEST_BASE+index (16-bit add), Do_dma=latch, wr_dma_n=0. At the posedge ending WRITE: if index==LENGTH-1, go to IDLE; else index<=index+1 and go to READ.
- Timing
  - dma_active is high for exactly 1+2*LENGTH cycles (321 with defaults). It goes high the cycle after the trigger edge and drops the cycle after the final WRITE.
  - Outputs decode from registered state/index/latch only; there are no combinational paths from CPU inputs to bus strobes.
- Boundaries and simultaneous events
  - rd_dma_n and wr_dma_n are never low in the same cycle.
  - A_dma holds the last driven value in IDLE.
  - A trigger while DMA is active restarts: the new src_hi is loaded, index=0, state=SETUP. The in-flight byte is not written.
  - index is 8 bits; LENGTH=256 ends after index 255 with no wrap beyond.
  - Writes to other addresses have no effect. A CPU write to REG_ADDR coinciding with reset is ignored (reset wins).

Test Plan:
- Reset, then idle 10 cycles -> dma_active=0, rd_dma_n=wr_dma_n=1, Do_reg=00.
- CPU writes C1 to FF46 for one cycle, memory model returns data=low byte of address -> cycle+1 SETUP; cycle+2 A_dma=C100 rd_n=0; cycle+3 A_dma=FE00 wr_n=0 Do_dma=00; last write A_dma=FE9F Do_dma=9F; dma_active high exactly 321 cycles.
- Write FE to FF46 -> reads issued from DE00..DE9F; Do_reg reads back FE with cs_reg=1 when A_cpu=FF46.
- Hold wr_cpu_n low at FF46 for 3 cycles -> single trigger; transfer length still 321 cycles.
- Retrigger with 80 at byte index 50 (during READ) -> next READ at 8000 after SETUP; no write to FE32 from the old source; 321 more active cycles.
- Assert reset during WRITE of index 10 -> next cycle all strobes high, dma_active=0, Do_reg=00.

Source files
------------

// File: rtl/oam_dma_engine.sv
`timescale 1ns/1ps
// oam_dma_engine
//   OAM DMA register and bus initiator. A CPU write to REG_ADDR latches a
//   source page and starts a copy of LENGTH bytes from {src_hi, 8'h00} to
//   DEST_BASE. The engine alternates READ and WRITE bus cycles. While it owns
//   the bus it holds dma_active high, and the top level muxes the A_dma /
//   Do_dma / strobe outputs onto the memory controller and stalls the CPU.
//
// Ports
//   clock, reset  system clock; synchronous active-high reset
//   A_cpu         CPU address bus
//   Di_cpu        CPU write data
//   wr_cpu_n      CPU write strobe (active-low); falling edge at REG_ADDR triggers
//   Do_reg        readback of the last byte written to REG_ADDR
//   cs_reg        combinational decode of A_cpu == REG_ADDR
//   A_dma, Do_dma DMA bus address / write data (registered)
//   Di_dma        read data returned by the memory controller
//   rd_dma_n      DMA read strobe, active-low (registered)
//   wr_dma_n      DMA write strobe, active-low (registered)
//   dma_active    DMA owns the bus (registered)

module oam_dma_engine #(
  parameter logic [15:0] REG_ADDR  = 16'hFF46,
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter int unsigned LENGTH    = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  input  logic        wr_cpu_n,
  output logic [7:0]  Do_reg,
  output logic        cs_reg,
  output logic [15:0] A_dma,
  output logic [7:0]  Do_dma,
  input  logic [7:0]  Di_dma,
  output logic        rd_dma_n,
  output logic        wr_dma_n,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

  state_t     state;
  logic [7:0] src_hi;
  logic [7:0] index;
  logic [7:0] data_latch;
  logic       wr_prev;

  logic       trigger;
  logic [7:0] src_remap;

  assign cs_reg = (A_cpu == REG_ADDR);

  // Falling edge of the write strobe at the register address; a held-low
  // write therefore starts only one transfer.
  assign trigger = cs_reg && !wr_cpu_n && wr_prev;

  // Echo RAM pages E0..FF alias work RAM C0..DF.
  assign src_remap = (Di_cpu >= 8'hE0) ? (Di_cpu - 8'h20) : Di_cpu;

  // Bus outputs are registered together with the state, so each output
  // takes the value of the state being entered on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      Do_reg     <= '0;
      src_hi     <= '0;
      index      <= '0;
      data_latch <= '0;
      wr_prev    <= 1'b1;
      A_dma      <= '0;
      Do_dma     <= '0;
      rd_dma_n   <= 1'b1;
      wr_dma_n   <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      wr_prev <= wr_cpu_n;

      if (trigger) begin
        // Also handles restart mid-transfer: the in-flight byte is dropped.
        Do_reg     <= Di_cpu;
        src_hi     <= src_remap;
        index      <= '0;
        state      <= SETUP;
        dma_active <= 1'b1;
        rd_dma_n   <= 1'b1;
        wr_dma_n   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            rd_dma_n   <= 1'b1;
            wr_dma_n   <= 1'b1;
            dma_active <= 1'b0;
          end

          SETUP: begin
            state    <= READ;
            A_dma    <= {src_hi, index};
            rd_dma_n <= 1'b0;
            wr_dma_n <= 1'b1;
          end

          READ: begin
            // Do_dma mirrors the data latch, so it is loaded from the same source.
            data_latch <= Di_dma;
            Do_dma     <= Di_dma;
            state      <= WRITE;
            A_dma      <= DEST_BASE + {8'h00, index};
            rd_dma_n   <= 1'b1;
            wr_dma_n   <= 1'b0;
          end

          WRITE: begin
            wr_dma_n <= 1'b1;
            if (index == LAST_INDEX) begin
              state      <= IDLE;
              rd_dma_n   <= 1'b1;
              dma_active <= 1'b0;
            end else begin
              index    <= index + 8'd1;
              state    <= READ;
              A_dma    <= {src_hi, index + 8'd1};
              rd_dma_n <= 1'b0;
            end
          end

          default: begin
            state      <= IDLE;
            rd_dma_n   <= 1'b1;
            wr_dma_n   <= 1'b1;
            dma_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
`timescale 1ns/1ps
// Testbench for oam_dma_engine: table-driven transfers plus hand-written
// sequences for restart, held write, reset abort and idle behaviour. Bus
// reads/writes are checked against a scoreboard filled when each transfer
// is triggered.

module tb_oam_dma_engine;

  logic        clock;
  logic        reset;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu;
  logic        wr_cpu_n;
  logic [7:0]  Do_reg;
  logic        cs_reg;
  logic [15:0] A_dma;
  logic [7:0]  Do_dma;
  logic [7:0]  Di_dma;
  logic        rd_dma_n;
  logic        wr_dma_n;
  logic        dma_active;

  oam_dma_engine #(
    .REG_ADDR (16'hFF46),
    .DEST_BASE(16'hFE00),
    .LENGTH   (160)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .A_cpu     (A_cpu),
    .Di_cpu    (Di_cpu),
    .wr_cpu_n  (wr_cpu_n),
    .Do_reg    (Do_reg),
    .cs_reg    (cs_reg),
    .A_dma     (A_dma),
    .Do_dma    (Do_dma),
    .Di_dma    (Di_dma),
    .rd_dma_n  (rd_dma_n),
    .wr_dma_n  (wr_dma_n),
    .dma_active(dma_active)
  );

  localparam int unsigned LEN = 160;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: mode 0 returns the address low byte, mode 1 mixes in the page.
  logic mem_mode;
  assign Di_dma = A_dma[7:0] ^ (mem_mode ? A_dma[15:8] : 8'h00);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned active_cnt = 0;

  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flush the scoreboard and load the expectations for a new transfer.
  task automatic arm(input logic [7:0] src);
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < int'(LEN); i++) begin
      logic [7:0] ib;
      logic [7:0] d;
      ib = 8'(i);
      d  = ib ^ (mem_mode ? src : 8'h00);
      exp_rd.push_back({src, ib});
      exp_wr.push_back({16'hFE00 + 16'(i), d});
    end
    active_cnt = 0;
  endtask

  // Bus monitor: pops the scoreboard on every strobe.
  always @(negedge clock) begin
    if (dma_active) active_cnt++;
    check("strobe_overlap", 32'(rd_dma_n | wr_dma_n), 32'd1);
    if (!rd_dma_n) begin
      if (exp_rd.size() == 0) check("unexpected_read", {16'h0, A_dma}, 32'hFFFF_FFFF);
      else check("read_addr", {16'h0, A_dma}, {16'h0, exp_rd.pop_front()});
    end
    if (!wr_dma_n) begin
      if (exp_wr.size() == 0) check("unexpected_write", {8'h0, A_dma, Do_dma}, 32'hFFFF_FFFF);
      else check("write_addr_data", {8'h0, A_dma, Do_dma}, {8'h0, exp_wr.pop_front()});
    end
  end

  // Caller positions at a negedge. Arms the scoreboard just after the first
  // edge when a trigger is expected.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] v,
                           input int unsigned ncyc, input logic expect_trig,
                           input logic [7:0] src);
    A_cpu = addr;
    Di_cpu = v;
    wr_cpu_n = 1'b0;
    @(posedge clock);
    #1;
    if (expect_trig) arm(src);
    for (int unsigned k = 1; k < ncyc; k++) @(posedge clock);
    #1;
    wr_cpu_n = 1'b1;
    A_cpu = 16'h0000;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (dma_active && n < 2000);
    check({name, "_done_in_time"}, 32'(dma_active), 32'd0);
    check({name, "_active_cycles"}, active_cnt, 32'd321);
    check({name, "_reads_left"}, exp_rd.size(), 32'd0);
    check({name, "_writes_left"}, exp_wr.size(), 32'd0);
  endtask

  task automatic wait_bus(input logic want_read, input logic [15:0] addr, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if ((want_read ? !rd_dma_n : !wr_dma_n) && A_dma == addr) begin
        ok = 1'b1;
        break;
      end
    end
    check("bus_event_seen", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0] wdata;
    logic [7:0] exp_src;
    logic       mode;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    vecs[0] = '{8'hC1, 8'hC1, 1'b1};
    vecs[1] = '{8'hFE, 8'hDE, 1'b0};
    vecs[2] = '{8'hE0, 8'hC0, 1'b1};
    vecs[3] = '{8'hFF, 8'hDF, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b1};
    vecs[6] = '{8'hDF, 8'hDF, 1'b1};
    vecs[7] = '{8'hE1, 8'hC1, 1'b1};

    mem_mode = 1'b0;
    reset = 1'b1;
    A_cpu = 16'h0000;
    Di_cpu = 8'h00;
    wr_cpu_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state after idling.
    repeat (10) @(negedge clock);
    check("reset_active", 32'(dma_active), 32'd0);
    check("reset_strobes", 32'({rd_dma_n, wr_dma_n}), 32'b11);
    check("reset_do_reg", 32'(Do_reg), 32'h00);
    check("reset_a_dma", 32'(A_dma), 32'h0000);
    check("reset_do_dma", 32'(Do_dma), 32'h00);

    // Basic transfer with cycle-exact checks of the first bus cycles.
    mem_mode = 1'b0;
    cpu_write(16'hFF46, 8'hC1, 1, 1'b1, 8'hC1);
    @(negedge clock);
    check("setup_cycle", 32'({dma_active, rd_dma_n, wr_dma_n}), 32'b111);
    @(negedge clock);
    check("first_read", 32'({A_dma, rd_dma_n, wr_dma_n}), {14'h0, 16'hC100, 2'b01});
    @(negedge clock);
    check("first_write", 32'({A_dma, Do_dma, rd_dma_n, wr_dma_n}), {6'h0, 16'hFE00, 8'h00, 2'b10});
    wait_idle("c1");
    check("idle_hold_addr", 32'(A_dma), 32'hFE9F);
    check("idle_hold_data", 32'(Do_dma), 32'h9F);

    // Table-driven transfers including echo remap and register readback.
    for (int v = 0; v < 8; v++) begin
      mem_mode = vecs[v].mode;
      @(negedge clock);
      cpu_write(16'hFF46, vecs[v].wdata, 1, 1'b1, vecs[v].exp_src);
      wait_idle("table");
      A_cpu = 16'hFF46;
      #1;
      check("readback_cs", 32'(cs_reg), 32'd1);
      check("readback_do_reg", 32'(Do_reg), 32'(vecs[v].wdata));
      A_cpu = 16'hFF47;
      #1;
      check("other_addr_cs", 32'(cs_reg), 32'd0);
      A_cpu = 16'h0000;
    end

    // Write to a neighbouring address does nothing.
    @(negedge clock);
    cpu_write(16'hFF47, 8'h12, 1, 1'b0, 8'h00);
    active_cnt = 0;
    repeat (5) @(negedge clock);
    check("other_write_no_dma", active_cnt, 32'd0);
    check("other_write_do_reg", 32'(Do_reg), 32'hE1);

    // Held write triggers once.
    mem_mode = 1'b1;
    @(negedge clock);
    cpu_write(16'hFF46, 8'hC3, 3, 1'b1, 8'hC3);
    wait_idle("held_write");

    // Restart during READ of index 50.
    mem_mode = 1'b1;
    @(negedge clock);
    cpu_write(16'hFF46, 8'hC1, 1, 1'b1, 8'hC1);
    wait_bus(1'b1, 16'hC132, ok);
    cpu_write(16'hFF46, 8'h80, 1, 1'b1, 8'h80);
    @(negedge clock);
    check("restart_setup", 32'({dma_active, rd_dma_n, wr_dma_n}), 32'b111);
    @(negedge clock);
    check("restart_first_read", 32'({A_dma, rd_dma_n}), {15'h0, 16'h8000, 1'b0});
    wait_idle("restart");

    // Reset during WRITE of index 10, with a coinciding register write.
    mem_mode = 1'b0;
    @(negedge clock);
    cpu_write(16'hFF46, 8'hC2, 1, 1'b1, 8'hC2);
    wait_bus(1'b0, 16'hFE0A, ok);
    reset = 1'b1;
    A_cpu = 16'hFF46;
    Di_cpu = 8'h55;
    wr_cpu_n = 1'b0;
    @(posedge clock);
    #1;
    exp_rd.delete();
    exp_wr.delete();
    reset = 1'b0;
    wr_cpu_n = 1'b1;
    A_cpu = 16'h0000;
    active_cnt = 0;
    @(negedge clock);
    check("abort_strobes", 32'({rd_dma_n, wr_dma_n}), 32'b11);
    check("abort_active", 32'(dma_active), 32'd0);
    check("abort_do_reg", 32'(Do_reg), 32'h00);
    repeat (20) @(negedge clock);
    check("abort_stays_idle", active_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
